// File: rtl/hazard_ctrl_if.sv
// Decoder-side inputs and pipeline-control outputs of the hazard/sequencing unit.
// The core-side control block drives the master view; hazard_ctrl takes the slave view.
interface hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
);
    logic              Instr_Valid;
    logic [REG_AW-1:0] Ra;
    logic [REG_AW-1:0] Rb;
    logic              Ra_Used;
    logic              Rb_Used;
    logic [REG_AW-1:0] Rd;
    logic              RegWr;
    logic              MemtoReg;
    logic              MemWr;
    logic              Redirect;
    logic              Mem_Ready;
    logic              PC_En;
    logic              IFID_En;
    logic              IFID_Flush;
    logic              IDEX_Flush;
    logic              EXMEM_Flush;
    logic [1:0]        ForwardA;
    logic [1:0]        ForwardB;
    logic [CNT_W-1:0]  Stall_Count;
    logic [CNT_W-1:0]  Flush_Count;

    modport master (
        output Instr_Valid, Ra, Rb, Ra_Used, Rb_Used, Rd, RegWr, MemtoReg, MemWr,
               Redirect, Mem_Ready,
        input  PC_En, IFID_En, IFID_Flush, IDEX_Flush, EXMEM_Flush, ForwardA, ForwardB,
               Stall_Count, Flush_Count
    );

    modport slave (
        input  Instr_Valid, Ra, Rb, Ra_Used, Rb_Used, Rd, RegWr, MemtoReg, MemWr,
               Redirect, Mem_Ready,
        output PC_En, IFID_En, IFID_Flush, IDEX_Flush, EXMEM_Flush, ForwardA, ForwardB,
               Stall_Count, Flush_Count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing for the 5-stage core: freeze/redirect/load-use arbitration,
// EX operand forwarding from a shadow of the EX/MEM/WB occupants, stall/flush counters.
module hazard_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic          Clk,
    input  logic          Reset,
    hazard_ctrl_if.slave  bus
);
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] ra;
        logic [REG_AW-1:0] rb;
        logic              ra_used;
        logic              rb_used;
        logic [REG_AW-1:0] rd;
        logic              regwr;
        logic              load;
        logic              memop;
    } entry_t;

    localparam entry_t BUBBLE = '0;

    entry_t           e_q, m_q, w_q;
    entry_t           e_d, m_d, w_d;
    entry_t           id_entry;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             freeze;
    logic             load_use;
    logic             m_fwd_ok;
    logic             w_fwd_ok;
    logic             unused_w;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // An invalid ID slot enters EX as a clean bubble so stale fields never forward.
    always_comb begin
        id_entry = BUBBLE;
        if (bus.Instr_Valid) begin
            id_entry.valid   = 1'b1;
            id_entry.ra      = bus.Ra;
            id_entry.rb      = bus.Rb;
            id_entry.ra_used = bus.Ra_Used;
            id_entry.rb_used = bus.Rb_Used;
            id_entry.rd      = bus.Rd;
            id_entry.regwr   = bus.RegWr;
            id_entry.load    = bus.MemtoReg;
            id_entry.memop   = bus.MemtoReg | bus.MemWr;
        end
    end

    assign freeze   = m_q.valid & m_q.memop & ~bus.Mem_Ready;
    assign load_use = bus.Instr_Valid & e_q.valid & e_q.load & (e_q.rd != '0) &
                      ((bus.Ra_Used & (bus.Ra == e_q.rd)) | (bus.Rb_Used & (bus.Rb == e_q.rd)));

    // Loads in MEM have no result yet; x0 is never a forwarding source.
    assign m_fwd_ok = m_q.valid & m_q.regwr & ~m_q.load & (m_q.rd != '0);
    assign w_fwd_ok = w_q.valid & w_q.regwr & (w_q.rd != '0);

    always_comb begin
        bus.ForwardA = 2'b00;
        if (e_q.ra_used && m_fwd_ok && (m_q.rd == e_q.ra))      bus.ForwardA = 2'b01;
        else if (e_q.ra_used && w_fwd_ok && (w_q.rd == e_q.ra)) bus.ForwardA = 2'b10;
        bus.ForwardB = 2'b00;
        if (e_q.rb_used && m_fwd_ok && (m_q.rd == e_q.rb))      bus.ForwardB = 2'b01;
        else if (e_q.rb_used && w_fwd_ok && (w_q.rd == e_q.rb)) bus.ForwardB = 2'b10;
    end

    // Priority arbitration: freeze > redirect > load-use > normal advance.
    always_comb begin
        bus.PC_En       = 1'b1;
        bus.IFID_En     = 1'b1;
        bus.IFID_Flush  = 1'b0;
        bus.IDEX_Flush  = 1'b0;
        bus.EXMEM_Flush = 1'b0;
        e_d             = id_entry;
        m_d             = e_q;
        w_d             = m_q;
        stall_d         = stall_q;
        flush_d         = flush_q;
        if (freeze) begin
            bus.PC_En   = 1'b0;
            bus.IFID_En = 1'b0;
            e_d         = e_q;
            m_d         = m_q;
            w_d         = w_q;
            stall_d     = sat_inc(stall_q);
        end else if (bus.Redirect) begin
            bus.IFID_Flush  = 1'b1;
            bus.IDEX_Flush  = 1'b1;
            bus.EXMEM_Flush = 1'b1;
            e_d             = BUBBLE;
            m_d             = BUBBLE;
            flush_d         = sat_inc(flush_q);
        end else if (load_use) begin
            bus.PC_En      = 1'b0;
            bus.IFID_En    = 1'b0;
            bus.IDEX_Flush = 1'b1;
            e_d            = BUBBLE;
            stall_d        = sat_inc(stall_q);
        end
        if (Reset) begin
            bus.PC_En       = 1'b0;
            bus.IFID_En     = 1'b0;
            bus.IFID_Flush  = 1'b1;
            bus.IDEX_Flush  = 1'b1;
            bus.EXMEM_Flush = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            e_q     <= BUBBLE;
            m_q     <= BUBBLE;
            w_q     <= BUBBLE;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            e_q     <= e_d;
            m_q     <= m_d;
            w_q     <= w_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign bus.Stall_Count = stall_q;
    assign bus.Flush_Count = flush_q;

    // WB source fields are shadowed for symmetry but only rd/regwr/valid matter there.
    assign unused_w = ^w_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: cycle-by-cycle vector table plus hand sequences
// for memory freeze, reset during freeze and counter saturation.
module tb_hazard_ctrl;
    logic clk;
    logic rst;

    hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) bus();
    hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  bus4();

    hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut  (.Clk(clk), .Reset(rst), .bus(bus));
    hazard_ctrl #(.REG_AW(5), .CNT_W(4))  dut4 (.Clk(clk), .Reset(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word: {PC_En, IFID_En, IFID_Flush, IDEX_Flush, EXMEM_Flush, FA[1:0], FB[1:0]}
    localparam logic [8:0] NRM = 9'b11_000_0000;
    localparam logic [8:0] LU  = 9'b00_010_0000;
    localparam logic [8:0] RD  = 9'b11_111_0000;
    localparam logic [8:0] FRZ = 9'b00_000_0000;
    localparam logic [8:0] RST = 9'b00_111_0000;
    localparam logic [8:0] A01 = 9'd4;
    localparam logic [8:0] A10 = 9'd8;
    localparam logic [8:0] B01 = 9'd1;
    localparam logic [8:0] B10 = 9'd2;

    typedef struct {
        logic       v;
        logic [4:0] ra;
        logic [4:0] rb;
        logic       rau;
        logic       rbu;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       st;
        logic       redir;
        logic       rdy;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                                input logic rau, input logic rbu, input logic [4:0] rd,
                                input logic wr, input logic ld, input logic [8:0] exp);
        vec_t x;
        x.v = v; x.ra = ra; x.rb = rb; x.rau = rau; x.rbu = rbu; x.rd = rd;
        x.wr = wr; x.ld = ld; x.st = 1'b0; x.redir = 1'b0; x.rdy = 1'b1; x.exp = exp;
        return x;
    endfunction

    function automatic vec_t alu(input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb,
                                 input logic [8:0] exp);
        return mk(1'b1, ra, rb, 1'b1, 1'b1, rd, 1'b1, 1'b0, exp);
    endfunction

    function automatic vec_t lw(input logic [4:0] rd, input logic [4:0] ra, input logic [8:0] exp);
        return mk(1'b1, ra, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, exp);
    endfunction

    function automatic vec_t beq(input logic [4:0] ra, input logic [4:0] rb, input logic [8:0] exp);
        return mk(1'b1, ra, rb, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, exp);
    endfunction

    function automatic vec_t jal(input logic [4:0] rd, input logic [8:0] exp);
        return mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, rd, 1'b1, 1'b0, exp);
    endfunction

    function automatic vec_t nop(input logic [8:0] exp);
        return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, exp);
    endfunction

    function automatic vec_t with_redir(input vec_t x);
        vec_t y;
        y = x;
        y.redir = 1'b1;
        return y;
    endfunction

    function automatic vec_t with_rdy(input vec_t x, input logic rdy, input logic redir);
        vec_t y;
        y = x;
        y.rdy = rdy;
        y.redir = redir;
        return y;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [8:0] ctl();
        return {bus.PC_En, bus.IFID_En, bus.IFID_Flush, bus.IDEX_Flush, bus.EXMEM_Flush,
                bus.ForwardA, bus.ForwardB};
    endfunction

    task automatic drive(input vec_t x);
        bus.Instr_Valid = x.v;
        bus.Ra          = x.ra;
        bus.Rb          = x.rb;
        bus.Ra_Used     = x.rau;
        bus.Rb_Used     = x.rbu;
        bus.Rd          = x.rd;
        bus.RegWr       = x.wr;
        bus.MemtoReg    = x.ld;
        bus.MemWr       = x.st;
        bus.Redirect    = x.redir;
        bus.Mem_Ready   = x.rdy;
    endtask

    // One pipeline cycle: drive after the falling edge, check mid-low-phase, commit on the rising edge.
    task automatic apply(input vec_t x, input string nm);
        @(negedge clk);
        drive(x);
        #2;
        chk(nm, 32'(ctl()), 32'(x.exp));
    endtask

    task automatic drive4(input vec_t x);
        bus4.Instr_Valid = x.v;
        bus4.Ra          = x.ra;
        bus4.Rb          = x.rb;
        bus4.Ra_Used     = x.rau;
        bus4.Rb_Used     = x.rbu;
        bus4.Rd          = x.rd;
        bus4.RegWr       = x.wr;
        bus4.MemtoReg    = x.ld;
        bus4.MemWr       = x.st;
        bus4.Redirect    = x.redir;
        bus4.Mem_Ready   = x.rdy;
    endtask

    initial begin
        rst = 1'b1;
        drive(nop(NRM));
        drive4(nop(NRM));

        // Load-use, ALU forwarding, x0 and MEM-over-WB priority, redirects.
        vecs.push_back(lw(5'd5, 5'd1, NRM));
        vecs.push_back(alu(5'd6, 5'd5, 5'd2, LU));
        vecs.push_back(alu(5'd6, 5'd5, 5'd2, NRM));
        vecs.push_back(nop(NRM | A10));
        vecs.push_back(alu(5'd3, 5'd1, 5'd2, NRM));
        vecs.push_back(alu(5'd4, 5'd3, 5'd3, NRM));
        vecs.push_back(alu(5'd7, 5'd3, 5'd0, NRM | A01 | B01));
        vecs.push_back(nop(NRM | A10));
        vecs.push_back(alu(5'd0, 5'd1, 5'd2, NRM));
        vecs.push_back(alu(5'd4, 5'd0, 5'd0, NRM));
        vecs.push_back(alu(5'd8, 5'd1, 5'd1, NRM));
        vecs.push_back(alu(5'd8, 5'd2, 5'd2, NRM));
        vecs.push_back(alu(5'd9, 5'd8, 5'd0, NRM));
        vecs.push_back(nop(NRM | A01));
        vecs.push_back(nop(NRM));
        vecs.push_back(nop(NRM));
        vecs.push_back(beq(5'd1, 5'd2, NRM));
        vecs.push_back(lw(5'd5, 5'd3, NRM));
        vecs.push_back(with_redir(alu(5'd6, 5'd5, 5'd5, RD)));
        vecs.push_back(nop(NRM));
        vecs.push_back(jal(5'd1, NRM));
        vecs.push_back(alu(5'd2, 5'd1, 5'd0, NRM));
        vecs.push_back(with_redir(nop(RD | A01)));
        vecs.push_back(nop(NRM));

        @(negedge clk);
        #2;
        chk("reset_ctl", 32'(ctl()), 32'(RST));
        chk("reset_stall", bus.Stall_Count, 32'd0);
        chk("reset_flush", bus.Flush_Count, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end
        chk("stall_after_table", bus.Stall_Count, 32'd1);
        chk("flush_after_table", bus.Flush_Count, 32'd2);

        // Memory freeze for three cycles with a redirect pulse in the middle.
        apply(alu(5'd3, 5'd1, 5'd1, NRM), "frz_setup0");
        apply(lw(5'd5, 5'd3, NRM), "frz_setup1");
        apply(alu(5'd7, 5'd3, 5'd3, NRM | A01), "frz_setup2");
        apply(with_rdy(nop(FRZ | A10 | B10), 1'b0, 1'b0), "frz_c0");
        apply(with_rdy(nop(FRZ | A10 | B10), 1'b0, 1'b1), "frz_c1_redir");
        apply(with_rdy(nop(FRZ | A10 | B10), 1'b0, 1'b0), "frz_c2");
        apply(nop(NRM | A10 | B10), "frz_release");
        chk("frz_stall", bus.Stall_Count, 32'd4);
        chk("frz_flush", bus.Flush_Count, 32'd2);

        // Reset arriving in the middle of a freeze.
        apply(lw(5'd5, 5'd1, NRM), "rstfrz_setup0");
        apply(nop(NRM), "rstfrz_setup1");
        apply(with_rdy(nop(FRZ), 1'b0, 1'b0), "rstfrz_frozen");
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("rstfrz_ctl", 32'(ctl()), 32'(RST));
        chk("rstfrz_stall", bus.Stall_Count, 32'd0);
        chk("rstfrz_flush", bus.Flush_Count, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("post_rst_ctl", 32'(ctl()), 32'(NRM));

        // Saturation of a 4-bit stall counter under a 20-cycle freeze.
        @(negedge clk);
        drive4(lw(5'd5, 5'd1, NRM));
        @(negedge clk);
        drive4(nop(NRM));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive4(with_rdy(nop(FRZ), 1'b0, 1'b0));
        end
        @(negedge clk);
        #2;
        chk("sat_stall", 32'(bus4.Stall_Count), 32'd15);
        chk("sat_pc_en", 32'(bus4.PC_En), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
